la_status_seq_monitor: RTL and testbench

//  Synthesizable, parametrised checker for firmware progress codes on an LA status field, for standalone mgmt-core benches and on-chip self-test.

---
 rtl/la_status_seq_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_la_status_seq_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/la_status_seq_monitor.sv
// la_status_seq_monitor
// Watches a firmware progress code and checks that a programmed ordered list of
// codes appears, each held stable for STABLE_CYCLES, before a global timeout.
// Reports busy/started/passed/failed, the accepted step count and a heartbeat.
module la_status_seq_monitor #(
  parameter int STATUS_W       = 4,
  parameter int DEPTH          = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int HEARTBEAT      = 1000
) (
  input  logic                         core_clk,
  input  logic                         core_rstn,
  input  logic                         enable,
  input  logic [DEPTH*STATUS_W-1:0]    seq_codes,
  input  logic [$clog2(DEPTH+1)-1:0]   seq_len,
  input  logic [STATUS_W-1:0]          status,
  output logic                         busy,
  output logic                         started,
  output logic                         passed,
  output logic                         failed,
  output logic [$clog2(DEPTH+1)-1:0]   step,
  output logic                         hb_tick
);

  localparam int STEP_W = $clog2(DEPTH + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HB_W   = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Select the expected code for a given step index (index < DEPTH while running).
  function automatic logic [STATUS_W-1:0] code_at(
    input logic [DEPTH*STATUS_W-1:0] codes,
    input logic [STEP_W-1:0]         idx
  );
    code_at = {STATUS_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      code_at = (idx == STEP_W'(k)) ? codes[k*STATUS_W +: STATUS_W] : code_at;
    end
  endfunction

  state_t                      state_r, state_nx_s;
  logic                        en_d_r, en_d_nx_s;
  logic [DEPTH*STATUS_W-1:0]   codes_r, codes_nx_s;
  logic [STEP_W-1:0]           len_r, len_nx_s;
  logic [STEP_W-1:0]           step_r, step_nx_s;
  logic [STAB_W-1:0]           stab_r, stab_nx_s;
  logic [TMO_W-1:0]            tmo_r, tmo_nx_s;
  logic [HB_W-1:0]             hb_r, hb_nx_s;
  logic                        busy_r, busy_nx_s;
  logic                        started_r, started_nx_s;
  logic                        passed_r, passed_nx_s;
  logic                        failed_r, failed_nx_s;
  logic                        hb_tick_r, hb_tick_nx_s;

  logic                        rise_s;
  logic [STEP_W-1:0]           len_clamp_s;
  logic                        match_s;
  logic                        accept_s;
  logic [STAB_W-1:0]           stab_inc_s, stab_run_s;
  logic [STEP_W-1:0]           step_run_s;
  logic [TMO_W-1:0]            tmo_run_s;
  logic [HB_W-1:0]             hb_run_s;
  logic                        hb_wrap_s;

  // Per-cycle RUN datapath: stability filter, step advance, saturating timeout and heartbeat.
  always_comb begin
    rise_s      = enable & ~en_d_r;
    len_clamp_s = (seq_len > STEP_W'(DEPTH)) ? STEP_W'(DEPTH) : seq_len;
    match_s     = (status == code_at(codes_r, step_r));
    stab_inc_s  = (stab_r == {STAB_W{1'b1}}) ? stab_r : stab_r + STAB_W'(1);
    accept_s    = match_s && (stab_inc_s == STAB_W'(STABLE_CYCLES));
    tmo_run_s   = (tmo_r == {TMO_W{1'b1}}) ? tmo_r : tmo_r + TMO_W'(1);
    if (!match_s) begin
      stab_run_s = STAB_W'(0);
      step_run_s = step_r;
    end else if (accept_s) begin
      // Each acceptance restarts the filter, so repeated codes need a fresh hold.
      stab_run_s = STAB_W'(0);
      step_run_s = (step_r == STEP_W'(DEPTH)) ? step_r : step_r + STEP_W'(1);
    end else begin
      stab_run_s = stab_inc_s;
      step_run_s = step_r;
    end
    if (HEARTBEAT == 0) begin
      hb_run_s  = HB_W'(0);
      hb_wrap_s = 1'b0;
    end else if (hb_r >= HB_W'(HEARTBEAT - 1)) begin
      hb_run_s  = HB_W'(0);
      hb_wrap_s = 1'b1;
    end else begin
      hb_run_s  = hb_r + HB_W'(1);
      hb_wrap_s = 1'b0;
    end
  end

  // Next-state and next-output logic for IDLE/RUN/PASS/FAIL.
  always_comb begin
    state_nx_s   = state_r;
    en_d_nx_s    = enable;
    codes_nx_s   = codes_r;
    len_nx_s     = len_r;
    step_nx_s    = step_r;
    stab_nx_s    = stab_r;
    tmo_nx_s     = tmo_r;
    hb_nx_s      = hb_r;
    busy_nx_s    = busy_r;
    started_nx_s = started_r;
    passed_nx_s  = passed_r;
    failed_nx_s  = failed_r;
    hb_tick_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          codes_nx_s   = seq_codes;
          len_nx_s     = len_clamp_s;
          step_nx_s    = STEP_W'(0);
          stab_nx_s    = STAB_W'(0);
          tmo_nx_s     = TMO_W'(0);
          hb_nx_s      = HB_W'(0);
          started_nx_s = 1'b0;
          failed_nx_s  = 1'b0;
          if (len_clamp_s == STEP_W'(0)) begin
            // Empty sequence is trivially satisfied.
            state_nx_s  = ST_PASS;
            busy_nx_s   = 1'b0;
            passed_nx_s = 1'b1;
          end else begin
            state_nx_s  = ST_RUN;
            busy_nx_s   = 1'b1;
            passed_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = ST_IDLE;
          busy_nx_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // Abort keeps started/step visible for post-mortem inspection.
          state_nx_s = ST_IDLE;
          busy_nx_s  = 1'b0;
        end else begin
          stab_nx_s    = stab_run_s;
          step_nx_s    = step_run_s;
          tmo_nx_s     = tmo_run_s;
          hb_nx_s      = hb_run_s;
          started_nx_s = started_r | (accept_s & (step_r == STEP_W'(0)));
          if (step_run_s == len_r) begin
            // Final accept beats a coincident timeout.
            state_nx_s  = ST_PASS;
            busy_nx_s   = 1'b0;
            passed_nx_s = 1'b1;
          end else if (tmo_run_s == TMO_W'(TIMEOUT_CYCLES)) begin
            state_nx_s  = ST_FAIL;
            busy_nx_s   = 1'b0;
            failed_nx_s = 1'b1;
          end else begin
            state_nx_s   = ST_RUN;
            busy_nx_s    = 1'b1;
            hb_tick_nx_s = hb_wrap_s;
          end
        end
      end
      ST_PASS, ST_FAIL: begin
        if (!enable) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
        busy_nx_s = 1'b0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state_r   <= ST_IDLE;
      en_d_r    <= 1'b0;
      codes_r   <= {(DEPTH*STATUS_W){1'b0}};
      len_r     <= STEP_W'(0);
      step_r    <= STEP_W'(0);
      stab_r    <= STAB_W'(0);
      tmo_r     <= TMO_W'(0);
      hb_r      <= HB_W'(0);
      busy_r    <= 1'b0;
      started_r <= 1'b0;
      passed_r  <= 1'b0;
      failed_r  <= 1'b0;
      hb_tick_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      en_d_r    <= en_d_nx_s;
      codes_r   <= codes_nx_s;
      len_r     <= len_nx_s;
      step_r    <= step_nx_s;
      stab_r    <= stab_nx_s;
      tmo_r     <= tmo_nx_s;
      hb_r      <= hb_nx_s;
      busy_r    <= busy_nx_s;
      started_r <= started_nx_s;
      passed_r  <= passed_nx_s;
      failed_r  <= failed_nx_s;
      hb_tick_r <= hb_tick_nx_s;
    end
  end

  assign busy    = busy_r;
  assign started = started_r;
  assign passed  = passed_r;
  assign failed  = failed_r;
  assign step    = step_r;
  assign hb_tick = hb_tick_r;

endmodule

// File: tb/tb_la_status_seq_monitor.sv
// Bench for la_status_seq_monitor: table of per-cycle vectors plus hand-written
// corner sequences; expectations are queued when driven and checked after the edge.
module tb_la_status_seq_monitor;
  localparam int SW = 4;
  localparam int DP = 4;
  localparam int SL = $clog2(DP + 1);

  logic          core_clk = 1'b0;
  logic          core_rstn;
  logic          enable;
  logic [DP*SW-1:0] seq_codes;
  logic [SL-1:0] seq_len;
  logic [SW-1:0] status;
  logic          busy, started, passed, failed, hb_tick;
  logic [SL-1:0] step;
  logic [7:0]    out_s;

  la_status_seq_monitor #(
    .STATUS_W(SW), .DEPTH(DP), .STABLE_CYCLES(2),
    .TIMEOUT_CYCLES(100), .HEARTBEAT(10)
  ) dut (
    .core_clk(core_clk), .core_rstn(core_rstn), .enable(enable),
    .seq_codes(seq_codes), .seq_len(seq_len), .status(status),
    .busy(busy), .started(started), .passed(passed), .failed(failed),
    .step(step), .hb_tick(hb_tick)
  );

  always #5 core_clk = ~core_clk;

  assign out_s = {busy, started, passed, failed, step, hb_tick};

  localparam logic [7:0] OB = 8'h80;
  localparam logic [7:0] OS = 8'h40;
  localparam logic [7:0] OP = 8'h20;
  localparam logic [7:0] OF = 8'h10;
  localparam logic [7:0] OT = 8'h01;

  function automatic logic [7:0] stp(input int n);
    stp = 8'((n & 7) << 1);
  endfunction

  typedef struct {
    logic       en;
    logic [3:0] st;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    string      nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input int n, input logic en, input logic [3:0] st,
                              input logic [7:0] exp, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en = en; v.st = st; v.exp = exp; v.nm = nm;
      tbl.push_back(v);
    end
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic en, input logic [3:0] st, input logic [7:0] exp, input string nm);
    sb_t e;
    enable = en;
    status = st;
    e.exp  = exp;
    e.nm   = nm;
    sb_q.push_back(e);
    @(posedge core_clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (out_s !== e.exp) begin
      failures++;
      $display("FAIL %s t=%0t: got=%b expected=%b (busy,started,passed,failed,step[2:0],hb_tick)",
               e.nm, $time, out_s, e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    core_rstn = 1'b0; enable = 1'b0; status = 4'h0;
    seq_codes = 16'h0000; seq_len = 3'd0;

    // Table: run-to-pass, glitch filter, abort/restart/heartbeat, timeout.
    add(1, 1'b1, 4'h0, OB, "t1_start");
    add(1, 1'b1, 4'h5, OB, "t1_s0_first");
    add(1, 1'b1, 4'h5, OB | OS | stp(1), "t1_acc0");
    add(7, 1'b1, 4'h5, OB | OS | stp(1), "t1_hold5");
    add(1, 1'b1, 4'h5, OB | OS | stp(1) | OT, "t1_hb10");
    add(1, 1'b1, 4'hA, OB | OS | stp(1), "t1_a_first");
    add(1, 1'b1, 4'hA, OB | OS | stp(2), "t1_acc1");
    add(7, 1'b1, 4'hA, OB | OS | stp(2), "t1_holdA");
    add(1, 1'b1, 4'hA, OB | OS | stp(2) | OT, "t1_hb20");
    add(1, 1'b1, 4'hC, OB | OS | stp(2), "t1_c_first");
    add(1, 1'b1, 4'hC, OS | OP | stp(3), "t1_pass");
    add(8, 1'b1, 4'hC, OS | OP | stp(3), "t1_pass_hold");
    add(1, 1'b0, 4'h0, OS | OP | stp(3), "t1_idle_keep");
    add(1, 1'b1, 4'h0, OB, "t2_start");
    add(1, 1'b1, 4'h5, OB, "t2_glitch");
    add(5, 1'b1, 4'h0, OB, "t2_nomatch");
    add(1, 1'b1, 4'h5, OB, "t2_s1");
    add(1, 1'b1, 4'h5, OB | OS | stp(1), "t2_acc");
    add(1, 1'b0, 4'h0, OS | stp(1), "t6_abort");
    add(1, 1'b0, 4'h0, OS | stp(1), "t6_idle");
    add(1, 1'b1, 4'h0, OB, "t6_restart");
    add(9, 1'b1, 4'h0, OB, "t6_run_a");
    add(1, 1'b1, 4'h0, OB | OT, "t6_hb10");
    add(9, 1'b1, 4'h0, OB, "t6_run_b");
    add(1, 1'b1, 4'h0, OB | OT, "t6_hb20");
    add(3, 1'b1, 4'h0, OB, "t6_run_c");
    add(1, 1'b0, 4'h0, 8'h00, "t6_abort2");
    add(2, 1'b0, 4'h0, 8'h00, "t6_idle_no_hb");
    add(1, 1'b1, 4'h5, OB, "t3_start");
    add(1, 1'b1, 4'h5, OB, "t3_s1");
    add(1, 1'b1, 4'h5, OB | OS | stp(1), "t3_acc");
    for (int k = 3; k < 100; k++) begin
      add(1, 1'b1, 4'h5, OB | OS | stp(1) | (((k % 10) == 0) ? OT : 8'h00), "t3_run");
    end
    add(1, 1'b1, 4'h5, OS | OF | stp(1), "t3_timeout");
    add(3, 1'b1, 4'h5, OS | OF | stp(1), "t3_fail_hold");
    add(1, 1'b0, 4'h5, OS | OF | stp(1), "t3_idle_keep");

    // Reset state.
    cyc(1'b0, 4'h0, 8'h00, "reset_a");
    cyc(1'b0, 4'h0, 8'h00, "reset_b");
    core_rstn = 1'b1;
    cyc(1'b0, 4'h0, 8'h00, "idle_after_reset");

    seq_codes = {4'h0, 4'hC, 4'hA, 4'h5};
    seq_len   = 3'd3;
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].st, tbl[i].exp, tbl[i].nm);
    end

    // Final accept and timeout land on the same edge.
    seq_codes = {12'h000, 4'h7};
    seq_len   = 3'd1;
    cyc(1'b1, 4'h0, OB, "t4_start");
    for (int k = 1; k < 99; k++) begin
      cyc(1'b1, 4'h0, OB | (((k % 10) == 0) ? OT : 8'h00), "t4_run");
    end
    cyc(1'b1, 4'h7, OB, "t4_s1");
    cyc(1'b1, 4'h7, OS | OP | stp(1), "t4_pass_wins");
    cyc(1'b1, 4'h7, OS | OP | stp(1), "t4_hold");
    cyc(1'b0, 4'h0, OS | OP | stp(1), "t4_idle");

    // Zero-length sequence.
    seq_len = 3'd0;
    cyc(1'b1, 4'h0, OP, "t5_len0_pass");
    cyc(1'b1, 4'h0, OP, "t5_len0_hold");
    cyc(1'b0, 4'h0, OP, "t5_len0_idle");

    // Repeated identical codes need a fresh hold each.
    seq_codes = {8'h00, 4'h3, 4'h3};
    seq_len   = 3'd2;
    cyc(1'b1, 4'h3, OB, "t5_rep_start");
    cyc(1'b1, 4'h3, OB, "t5_rep_s1");
    cyc(1'b1, 4'h3, OB | OS | stp(1), "t5_rep_acc0");
    cyc(1'b1, 4'h3, OB | OS | stp(1), "t5_rep_s1b");
    cyc(1'b1, 4'h3, OS | OP | stp(2), "t5_rep_pass");
    cyc(1'b0, 4'h0, OS | OP | stp(2), "t5_rep_idle");

    // Length above DEPTH clamps to DEPTH.
    seq_codes = {4'h4, 4'h3, 4'h2, 4'h1};
    seq_len   = 3'd7;
    cyc(1'b1, 4'h0, OB, "t5_clamp_start");
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1, 4'(c), OB | ((c > 1) ? OS : 8'h00) | stp(c - 1), "t5_clamp_s1");
      cyc(1'b1, 4'(c), (c < 4) ? (OB | OS | stp(c)) : (OS | OP | stp(4)), "t5_clamp_acc");
    end
    cyc(1'b0, 4'h0, OS | OP | stp(4), "t5_clamp_idle");

    // Reset in the middle of a run.
    seq_codes = {4'h0, 4'hC, 4'hA, 4'h5};
    seq_len   = 3'd3;
    cyc(1'b1, 4'h5, OB, "rst_start");
    cyc(1'b1, 4'h5, OB, "rst_s1");
    cyc(1'b1, 4'h5, OB | OS | stp(1), "rst_acc");
    core_rstn = 1'b0;
    cyc(1'b0, 4'h5, 8'h00, "rst_midrun");
    core_rstn = 1'b1;
    cyc(1'b0, 4'h0, 8'h00, "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
